fpu_issue_sched: RTL

- In-order issue scheduler in front of the shared floating-point execution unit.
- Decides each cycle whether the decoded FP/FP-related instruction may start, based on:
  - RAW/WAW hazards on integer and float destinations;
  - occupancy of the iterative div/sqrt unit;
  - collisions on the single shared writeback port.
- Pulses the FPU enable and emits the writeback tag exactly when the result is due.
- Sits between decode/dispatch and the FPU; the writeback tag drives register-file write and forwarding.

---
 rtl/fpu_issue_sched_if.sv | 33 +++
 rtl/fpu_issue_sched.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fpu_issue_sched_if.sv
// Dispatch-to-scheduler bundle: issue request and handshake, flush, FPU start and writeback tag.
interface fpu_issue_sched_if;
    logic       flush;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] issue_cls;
    logic [4:0] issue_rd;
    logic       issue_rd_f;
    logic [4:0] issue_rs1;
    logic       issue_rs1_f;
    logic       issue_rs1_en;
    logic [4:0] issue_rs2;
    logic       issue_rs2_f;
    logic       issue_rs2_en;
    logic       fpu_enabled;
    logic [2:0] fpu_cls;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_rd_f;
    logic       busy;

    modport master (
        output flush, issue_valid, issue_cls, issue_rd, issue_rd_f,
               issue_rs1, issue_rs1_f, issue_rs1_en, issue_rs2, issue_rs2_f, issue_rs2_en,
        input  issue_ready, fpu_enabled, fpu_cls, wb_valid, wb_rd, wb_rd_f, busy
    );

    modport slave (
        input  flush, issue_valid, issue_cls, issue_rd, issue_rd_f,
               issue_rs1, issue_rs1_f, issue_rs1_en, issue_rs2, issue_rs2_f, issue_rs2_en,
        output issue_ready, fpu_enabled, fpu_cls, wb_valid, wb_rd, wb_rd_f, busy
    );
endinterface

// File: rtl/fpu_issue_sched.sv
// In-order FPU issue scheduler: hazard scoreboard, div/sqrt occupancy and writeback-slot reservation.
// Start pulse one cycle after accept, writeback L cycles after accept; issue_ready stalls dispatch combinationally.
module fpu_issue_sched #(
    parameter int LAT_MISC = 1,
    parameter int LAT_ADD  = 3,
    parameter int LAT_MUL  = 3,
    parameter int LAT_DIV  = 10,
    parameter int LAT_SQRT = 10,
    parameter int MAXLAT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    fpu_issue_sched_if.slave  bus
);
    localparam int LW = $clog2(MAXLAT + 1);

    // Slot k holds the op writing back k cycles from now; slot 0 is the live writeback tag.
    logic [MAXLAT:0]       r_vld;
    logic [MAXLAT:0][4:0]  r_rd;
    logic [MAXLAT:0]       r_rdf;
    logic [63:0]           r_pend;
    logic [LW-1:0]         r_div_cnt;
    logic                  r_fpu_en;
    logic [2:0]            r_fpu_cls;

    logic [2:0]    w_cls;
    logic [LW-1:0] w_lat;
    logic          w_is_div;
    logic [5:0]    w_wb_idx;
    logic [5:0]    w_rs1_idx;
    logic [5:0]    w_rs2_idx;
    logic [5:0]    w_rd_idx;
    logic          w_rs1_ok;
    logic          w_rs2_ok;
    logic          w_rd_ok;
    logic          w_slot_free;
    logic          w_div_free;
    logic          w_ready;
    logic          w_accept;
    logic [63:0]   w_pend_nxt;

    always_comb begin
        w_cls = (bus.issue_cls > 3'd4) ? 3'd0 : bus.issue_cls;
        case (w_cls)
            3'd1:    w_lat = LW'(LAT_ADD);
            3'd2:    w_lat = LW'(LAT_MUL);
            3'd3:    w_lat = LW'(LAT_DIV);
            3'd4:    w_lat = LW'(LAT_SQRT);
            default: w_lat = LW'(LAT_MISC);
        endcase
    end

    assign w_is_div  = (w_cls == 3'd3) || (w_cls == 3'd4);
    assign w_wb_idx  = {r_rdf[0], r_rd[0]};
    assign w_rs1_idx = {bus.issue_rs1_f, bus.issue_rs1};
    assign w_rs2_idx = {bus.issue_rs2_f, bus.issue_rs2};
    assign w_rd_idx  = {bus.issue_rd_f, bus.issue_rd};

    // A register being written back this cycle counts as available (bypass).
    assign w_rs1_ok    = !bus.issue_rs1_en || !r_pend[w_rs1_idx] || (r_vld[0] && (w_wb_idx == w_rs1_idx));
    assign w_rs2_ok    = !bus.issue_rs2_en || !r_pend[w_rs2_idx] || (r_vld[0] && (w_wb_idx == w_rs2_idx));
    assign w_rd_ok     = !r_pend[w_rd_idx] || (r_vld[0] && (w_wb_idx == w_rd_idx));
    assign w_slot_free = !r_vld[w_lat];
    assign w_div_free  = !w_is_div || (r_div_cnt == '0);
    assign w_ready     = !bus.flush && w_rs1_ok && w_rs2_ok && w_rd_ok && w_slot_free && w_div_free;
    assign w_accept    = bus.issue_valid && w_ready;

    // Set after clear so a WAW re-issue on the writeback cycle stays pending.
    always_comb begin
        w_pend_nxt = r_pend;
        if (r_vld[0])
            w_pend_nxt[w_wb_idx] = 1'b0;
        if (w_accept && (bus.issue_rd_f || (bus.issue_rd != 5'd0)))
            w_pend_nxt[w_rd_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_rd  <= '0;
            r_rdf <= '0;
        end else if (bus.flush) begin
            r_vld <= '0;
        end else begin
            for (int k = 0; k < MAXLAT; k++) begin
                if (w_accept && (w_lat == LW'(k + 1))) begin
                    r_vld[k] <= 1'b1;
                    r_rd[k]  <= bus.issue_rd;
                    r_rdf[k] <= bus.issue_rd_f;
                end else begin
                    r_vld[k] <= r_vld[k+1];
                    r_rd[k]  <= r_rd[k+1];
                    r_rdf[k] <= r_rdf[k+1];
                end
            end
            r_vld[MAXLAT] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend    <= '0;
            r_div_cnt <= '0;
        end else if (bus.flush) begin
            r_pend    <= '0;
            r_div_cnt <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_accept && w_is_div)
                r_div_cnt <= w_lat - LW'(1);
            else if (r_div_cnt != '0)
                r_div_cnt <= r_div_cnt - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fpu_en  <= 1'b0;
            r_fpu_cls <= 3'd0;
        end else begin
            r_fpu_en  <= w_accept;
            r_fpu_cls <= w_accept ? w_cls : 3'd0;
        end
    end

    assign bus.issue_ready = w_ready;
    assign bus.fpu_enabled = r_fpu_en;
    assign bus.fpu_cls     = r_fpu_cls;
    assign bus.wb_valid    = r_vld[0];
    assign bus.wb_rd       = r_rd[0];
    assign bus.wb_rd_f     = r_rdf[0];
    assign bus.busy        = (|r_vld[MAXLAT:1]) || (r_div_cnt != '0);
endmodule
